// File: rtl/fifo_sram_ctrl_if.sv
// FIFO user-side bundle for fifo_sram_ctrl: write/read strobes, data and status.
// The master side (user logic) drives data and strobes; the slave side (the
// controller) returns the last read word, the fill level and the flags.
interface fifo_sram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
);
  logic [DATA_W-1:0] in_data;
  logic              fifowr;
  logic              fiford;
  logic [DATA_W-1:0] out_data;
  logic              nfull;
  logic              nempty;
  logic              nafull;
  logic [ADDR_W:0]   level;

  modport master (
    output in_data, fifowr, fiford,
    input  out_data, nfull, nempty, nafull, level
  );

  modport slave (
    input  in_data, fifowr, fiford,
    output out_data, nfull, nempty, nafull, level
  );
endinterface

// File: rtl/fifo_sram_ctrl.sv
// fifo_sram_ctrl: FIFO built on an external asynchronous SRAM.
// Falling edges of the active-low fifowr/fiford strobes become requests that
// are latched until serviced by a three-phase SRAM access (setup, strobe,
// hold/capture). Writes take priority over reads; a write on a full FIFO or a
// read on an empty FIFO is dropped without touching the SRAM.
// Optional feature: define FIFO_ERR_FLAG_EN to add sticky ovf/udf outputs
// that record dropped writes and dropped reads until the next reset.
module fifo_sram_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int DEPTH     = 8,
  parameter int BASE_ADDR = 0,
  parameter int AF_LEVEL  = DEPTH - 1
) (
  input  logic              clk,
  input  logic              rst,
  fifo_sram_ctrl_if.slave   bus,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              rd,
  output logic              wr
`ifdef FIFO_ERR_FLAG_EN
  ,
  output logic              ovf,
  output logic              udf
`endif
);

  localparam int LEVEL_W = ADDR_W + 1;
  localparam logic [LEVEL_W-1:0] DEPTH_L  = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] AF_L     = LEVEL_W'(AF_LEVEL);
  localparam logic [ADDR_W-1:0]  PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]  BASE_L   = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    R_SETUP,
    R_STROBE,
    R_CAPTURE
  } state_t;

  state_t              state;
  logic                fifowr_q;
  logic                fiford_q;
  logic                wr_pend;
  logic                rd_pend;
  logic [DATA_W-1:0]   pend_data;
  logic [DATA_W-1:0]   wdata;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0]  level_q;
  logic [DATA_W-1:0]   out_q;

  logic wr_req;
  logic rd_req;
  logic wr_any;
  logic rd_any;
  logic full;
  logic empty;
  logic idle;
  logic start_w;
  logic start_r;
  logic drop_w;
  logic drop_r;
  logic w_active;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign wr_req = fifowr_q & ~bus.fifowr;
  assign rd_req = fiford_q & ~bus.fiford;

  // A request detected on this edge is serviced straight away when idle,
  // so the pending latch only matters while the FSM is busy.
  assign wr_any = wr_pend | wr_req;
  assign rd_any = rd_pend | rd_req;

  assign full    = (level_q == DEPTH_L);
  assign empty   = (level_q == '0);
  assign idle    = (state == IDLE);
  assign start_w = idle & wr_any & ~full;
  assign drop_w  = idle & wr_any & full;
  assign start_r = idle & rd_any & ~empty & ~start_w;
  assign drop_r  = idle & rd_any & empty & ~start_w;

  assign w_active  = (state == W_SETUP) | (state == W_STROBE) | (state == W_HOLD);
  assign sram_data = w_active ? wdata : {DATA_W{1'bz}};

  assign bus.out_data = out_q;
  assign bus.level    = level_q;
  assign bus.nfull    = ~full;
  assign bus.nempty   = ~empty;
  assign bus.nafull   = ~(level_q >= AF_L);

  // Strobe edge detection and request latching until the FSM takes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifowr_q  <= 1'b1;
      fiford_q  <= 1'b1;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      pend_data <= '0;
    end else begin
      fifowr_q <= bus.fifowr;
      fiford_q <= bus.fiford;
      if (start_w || drop_w) begin
        wr_pend <= 1'b0;
      end else if (wr_req) begin
        wr_pend <= 1'b1;
      end
      if (wr_req && !wr_pend) begin
        pend_data <= bus.in_data;
      end
      if (start_r || drop_r) begin
        rd_pend <= 1'b0;
      end else if (rd_req) begin
        rd_pend <= 1'b1;
      end
    end
  end

  // SRAM access sequencer with registered strobes, address, pointers and level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      address <= BASE_L;
      rd      <= 1'b1;
      wr      <= 1'b1;
      wdata   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      out_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_w) begin
            state   <= W_SETUP;
            address <= BASE_L + wr_ptr;
            wdata   <= wr_pend ? pend_data : bus.in_data;
          end else if (start_r) begin
            state   <= R_SETUP;
            address <= BASE_L + rd_ptr;
            rd      <= 1'b0;
          end
        end
        W_SETUP: begin
          state <= W_STROBE;
          wr    <= 1'b0;
        end
        W_STROBE: begin
          state <= W_HOLD;
          wr    <= 1'b1;
        end
        W_HOLD: begin
          state   <= IDLE;
          wr_ptr  <= ptr_inc(wr_ptr);
          level_q <= level_q + 1'b1;
        end
        R_SETUP: begin
          state <= R_STROBE;
        end
        R_STROBE: begin
          state <= R_CAPTURE;
          rd    <= 1'b1;
          out_q <= sram_data;
        end
        R_CAPTURE: begin
          state   <= IDLE;
          rd_ptr  <= ptr_inc(rd_ptr);
          level_q <= level_q - 1'b1;
        end
        default: begin
          state <= IDLE;
          rd    <= 1'b1;
          wr    <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  // Sticky overflow/underflow flags for requests dropped on full/empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (drop_w) begin
        ovf <= 1'b1;
      end
      if (drop_r) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sram_ctrl.sv
// Testbench for fifo_sram_ctrl with a behavioural SRAM and a transaction-level
// FIFO model (queue plus a per-operation busy countdown). Build with
// FIFO_ERR_FLAG_EN defined to also exercise the ovf/udf outputs.
module tb_fifo_sram_ctrl;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 11;
  localparam int DEPTH     = 8;
  localparam int BASE_ADDR = 0;
  localparam int AF_LEVEL  = DEPTH - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Free-running clock.
  always #5 clk = ~clk;

  fifo_sram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wire  [DATA_W-1:0] sram_data;
  logic [ADDR_W-1:0] address;
  logic              rd;
  logic              wr;
`ifdef FIFO_ERR_FLAG_EN
  logic              ovf;
  logic              udf;
`endif

  fifo_sram_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .BASE_ADDR(BASE_ADDR), .AF_LEVEL(AF_LEVEL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .address(address),
    .sram_data(sram_data),
    .rd(rd),
    .wr(wr)
`ifdef FIFO_ERR_FLAG_EN
    ,
    .ovf(ovf),
    .udf(udf)
`endif
  );

  // Behavioural SRAM: drives the bus while output-enabled, stores while write-enabled.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  assign sram_data = !rd ? mem[address] : {DATA_W{1'bz}};
  always @(posedge clk) begin
    if (!wr) mem[address] <= sram_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state.
  logic [DATA_W-1:0] mq[$];
  int                m_busy;
  bit                m_op_w;
  bit                m_ww, m_rw;
  bit                m_pw, m_pr;
  logic [DATA_W-1:0] m_pdata, m_wdata, m_out;
  int                m_widx, m_ridx;
  bit                m_ovf, m_udf;

  // Model: each accepted operation occupies 3 clocks after the edge it starts on,
  // and a new one may start on the following edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_busy = 0; m_op_w = 0; m_ww = 0; m_rw = 0;
      m_pw = 1; m_pr = 1;
      m_pdata = '0; m_wdata = '0; m_out = '0;
      m_widx = 0; m_ridx = 0;
      m_ovf = 0; m_udf = 0;
    end else begin
      bit wdet, rdet, wstart;
      wdet = m_pw && !bus.fifowr;
      rdet = m_pr && !bus.fiford;
      m_pw = bus.fifowr;
      m_pr = bus.fiford;
      if (wdet && !m_ww) m_pdata = bus.in_data;
      m_ww = m_ww | wdet;
      m_rw = m_rw | rdet;
      if (m_busy > 0) begin
        m_busy--;
        if (!m_op_w && m_busy == 1) m_out = mq[0];
        if (m_busy == 0) begin
          if (m_op_w) begin
            mq.push_back(m_wdata);
            m_widx = (m_widx + 1) % DEPTH;
          end else begin
            void'(mq.pop_front());
            m_ridx = (m_ridx + 1) % DEPTH;
          end
        end
      end else begin
        wstart = 0;
        if (m_ww) begin
          m_ww = 0;
          if (mq.size() == DEPTH) m_ovf = 1;
          else begin
            wstart = 1; m_op_w = 1; m_wdata = m_pdata; m_busy = 3;
          end
        end
        if (m_rw && !wstart) begin
          m_rw = 0;
          if (mq.size() == 0) m_udf = 1;
          else begin
            m_op_w = 0; m_busy = 3;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("level", 32'(bus.level), 32'(mq.size()));
      checkOutput("nfull", 32'(bus.nfull), 32'(mq.size() != DEPTH));
      checkOutput("nempty", 32'(bus.nempty), 32'(mq.size() != 0));
      checkOutput("nafull", 32'(bus.nafull), 32'(!(mq.size() >= AF_LEVEL)));
      checkOutput("out_data", 32'(bus.out_data), 32'(m_out));
      checkOutput("wr", 32'(wr), 32'(!(m_op_w && m_busy == 2)));
      checkOutput("rd", 32'(rd), 32'(!(!m_op_w && (m_busy == 3 || m_busy == 2))));
      if (m_busy > 0)
        checkOutput("address", 32'(address), 32'(BASE_ADDR + (m_op_w ? m_widx : m_ridx)));
`ifdef FIFO_ERR_FLAG_EN
      checkOutput("ovf", 32'(ovf), 32'(m_ovf));
      checkOutput("udf", 32'(udf), 32'(m_udf));
`endif
    end
  end

  // Count write-address wraps from the last word back to the first.
  int wraps = 0;
  int last_waddr = -1;
  always @(negedge clk) begin
    if (!wr) begin
      if (last_waddr == DEPTH - 1 && address == ADDR_W'(0)) wraps++;
      last_waddr = int'(address);
    end
  end

  task automatic waitIdle();
    for (int i = 0; i < 40; i++) begin
      if (m_busy == 0 && !m_ww && !m_rw) return;
      @(negedge clk);
    end
    checkOutput("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic applyStimulus(input bit do_w, input bit do_r, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.fifowr  = !do_w;
    bus.fiford  = !do_r;
    bus.in_data = d;
    @(negedge clk);
    bus.fifowr = 1'b1;
    bus.fiford = 1'b1;
    waitIdle();
  endtask

  logic [DATA_W-1:0] vec [0:7] = '{8'hA5, 8'h3C, 8'h7E, 8'h01, 8'hFF, 8'h96, 8'h5A, 8'hC3};

  initial begin
    logic [DATA_W-1:0] d;
    bit                seen;
    bus.fifowr  = 1'b1;
    bus.fiford  = 1'b1;
    bus.in_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_out_data", 32'(bus.out_data), 32'h0);
    checkOutput("rst_nempty", 32'(bus.nempty), 32'd0);
    checkOutput("rst_nfull", 32'(bus.nfull), 32'd1);
    checkOutput("rst_nafull", 32'(bus.nafull), 32'd1);
    checkOutput("rst_level", 32'(bus.level), 32'd0);
    checkOutput("rst_rd", 32'(rd), 32'd1);
    checkOutput("rst_wr", 32'(wr), 32'd1);
    checkOutput("rst_address", 32'(address), 32'(BASE_ADDR));
    rst = 1'b0;

    $display("[TB] fill and overflow");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, vec[i]);
    checkOutput("full_level", 32'(bus.level), 32'd8);
    checkOutput("full_nfull", 32'(bus.nfull), 32'd0);
    checkOutput("full_nafull", 32'(bus.nafull), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'hEE);
    applyStimulus(1'b1, 1'b0, 8'hEF);
    checkOutput("ovf_level", 32'(bus.level), 32'd8);
`ifdef FIFO_ERR_FLAG_EN
    checkOutput("ovf_flag", 32'(ovf), 32'd1);
`endif

    $display("[TB] drain and underflow");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput("drain_data", 32'(bus.out_data), 32'(vec[i]));
    end
    checkOutput("drain_nempty", 32'(bus.nempty), 32'd0);
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("udf_out_data", 32'(bus.out_data), 32'hC3);
    checkOutput("udf_level", 32'(bus.level), 32'd0);
`ifdef FIFO_ERR_FLAG_EN
    checkOutput("udf_flag", 32'(udf), 32'd1);
`endif

    $display("[TB] alternating pairs with wrap");
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 37 + 5);
      applyStimulus(1'b1, 1'b0, d);
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput("pair_data", 32'(bus.out_data), 32'(d));
    end
    checkOutput("wrap_count", 32'(wraps), 32'd2);

    $display("[TB] simultaneous write and read at level 1");
    applyStimulus(1'b1, 1'b0, 8'hC3);
    applyStimulus(1'b1, 1'b1, 8'h3C);
    checkOutput("sim_out_data", 32'(bus.out_data), 32'hC3);
    checkOutput("sim_level", 32'(bus.level), 32'd1);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("sim_second", 32'(bus.out_data), 32'h3C);
    checkOutput("sim_level_end", 32'(bus.level), 32'd0);

    $display("[TB] reset during write strobe");
    @(negedge clk);
    bus.fifowr  = 1'b0;
    bus.in_data = 8'h77;
    @(negedge clk);
    bus.fifowr = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!wr) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("strobe_seen", 32'(seen), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_wr", 32'(wr), 32'd1);
    checkOutput("abort_level", 32'(bus.level), 32'd0);
    checkOutput("abort_nempty", 32'(bus.nempty), 32'd0);
    checkOutput("abort_address", 32'(address), 32'(BASE_ADDR));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("post_rst_out", 32'(bus.out_data), 32'h0);
    checkOutput("post_rst_level", 32'(bus.level), 32'd0);
`ifdef FIFO_ERR_FLAG_EN
    checkOutput("post_rst_ovf", 32'(ovf), 32'd0);
    checkOutput("post_rst_udf", 32'(udf), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fifo_sram_ctrl.md
FIFO_SRAM_CTRL -- requirements
Module: fifo_sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: FIFO and SRAM data width, in bits.
REQ-002 Parameter ADDR_W, default 11: SRAM address width, in bits.
REQ-003 Parameter DEPTH, default 8: FIFO capacity in words, with 2 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter BASE_ADDR, default 0: first SRAM word used by the FIFO; BASE_ADDR+DEPTH SHALL be <= 2**ADDR_W.
REQ-005 Parameter AF_LEVEL, default DEPTH-1: almost-full threshold.
REQ-006 clk  in  1  system clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 in_data  in  DATA_W  write data, sampled on the clk edge where a write request is detected.
REQ-009 fifowr  in  1  active-low write strobe; one write per high-to-low transition.
REQ-010 fiford  in  1  active-low read strobe; one read per high-to-low transition.
REQ-011 out_data  out  DATA_W  last word read, registered.
REQ-012 nfull  out  1  low when level==DEPTH.
REQ-013 nempty  out  1  low when level==0.
REQ-014 nafull  out  1  low when level>=AF_LEVEL.
REQ-015 level  out  ADDR_W+1  number of stored words.
REQ-016 address  out  ADDR_W  SRAM address.
REQ-017 sram_data  inout  DATA_W  SRAM data bus; driven only in write states, high-Z otherwise.
REQ-018 rd  out  1  active-low SRAM output enable.
REQ-019 wr  out  1  active-low SRAM write enable.

Function
REQ-020 fifowr and fiford SHALL each be registered once; a request SHALL be detected when the registered value is 1 and the current value is 0.
REQ-021 Pending write and read requests SHALL each be latched until the FSM starts servicing them.
REQ-022 FSM states: IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_CAPTURE.
REQ-023 Transitions from IDLE: to W_SETUP on a pending write, otherwise to R_SETUP on a pending read.
REQ-024 Other transitions: W_SETUP->W_STROBE->W_HOLD->IDLE and R_SETUP->R_STROBE->R_CAPTURE->IDLE, one clock each.
REQ-025 Write states: address=BASE_ADDR+wr_ptr, sram_data=latched in_data, and wr=0 only in W_STROBE.
REQ-026 Read states: address=BASE_ADDR+rd_ptr, and rd=0 in R_SETUP and R_STROBE.
REQ-027 On R_STROBE->R_CAPTURE, out_data SHALL load sram_data.
REQ-028 Leaving W_HOLD SHALL increment wr_ptr and level; leaving R_CAPTURE SHALL increment rd_ptr and decrement level.
REQ-029 nfull, nempty, nafull and level SHALL update on the same edge as the pointers.
REQ-030 Pointers SHALL wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
REQ-031 A write request while level==DEPTH SHALL be dropped: no SRAM cycle, no state change.
REQ-032 A read request while level==0 SHALL be dropped, and out_data SHALL hold its previous value.
REQ-033 When write and read requests are detected on the same edge, the write SHALL be serviced first and the read next, with no request lost.
REQ-034 A request arriving during a busy FSM SHALL stay latched; further edges of the same strobe before service SHALL merge into it.
REQ-035 Latency: 3 clocks per operation plus 1 clock for request detection.

Reset
REQ-036 When rst=1, asynchronously: FSM=IDLE, wr_ptr=rd_ptr=0, level=0, and pending requests cleared.
REQ-037 When rst=1, outputs SHALL be: out_data=0, nempty=0, nfull=1, nafull=1 (or 0 if AF_LEVEL==0), rd=1, wr=1, address=BASE_ADDR, sram_data high-Z, and the strobe registers=1.
REQ-038 Reset during any SRAM cycle SHALL abort it immediately; the in-flight operation SHALL not be counted.

Configuration
REQ-039 Macro FIFO_ERR_FLAG_EN, when defined, SHALL add output ports ovf and udf (1 bit each).
REQ-040 ovf SHALL set sticky on a write dropped by REQ-031, and udf SHALL set sticky on a read dropped by REQ-032; both SHALL clear only on rst.
REQ-041 Without FIFO_ERR_FLAG_EN, ovf and udf SHALL not exist and dropped requests SHALL be silent.

Verification
REQ-042 Scenario (defaults): reset -> nempty=0, nfull=1, level=0, rd=wr=1, sram_data high-Z.
REQ-043 Scenario (defaults): write 8 random words -> nfull=0 and level=8; write 2 more -> level stays 8 and ovf=1 (if enabled).
REQ-044 Scenario (defaults): read 8 -> data returned in write order, nempty=0 after the 8th; read 2 more -> out_data unchanged and udf=1 (if enabled).
REQ-045 Scenario (DEPTH=8): 16 alternating write/read pairs -> each read returns its own write, and address wraps 7->0 twice.
REQ-046 Scenario: fifowr and fiford fall on the same edge with level=1 -> write completes, then the read returns the oldest word, and level ends at 1.
REQ-047 Scenario: rst pulse during W_STROBE -> wr=1 immediately, level=0, and a following read is dropped.
